// File: rtl/fifo_read_streamer.sv
// Read-side streamer for synchronous_fifo: pops words, hides the 1-cycle read latency in a
// 2-entry skid buffer, and presents them as a valid/ready stream. Optional FIFO_RD_PARITY_EN adds out_parity.
module fifo_read_streamer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  flush_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
`ifdef FIFO_RD_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  wc_q, wc_d;
  logic                  flush_done_q, flush_done_d;
  logic                  busy_q, busy_d;
  logic                  transfer, flush_entry;
  logic [2:0]            occ;

  assign transfer = valid_q && out_ready;
  assign occ      = 3'(cnt_q) + 3'(inflight_q) - 3'(transfer);

  // Pop request stays combinational so it can never be raised against an empty FIFO.
  always_comb begin
    state_d      = state_q;
    fifo_rd_en   = 1'b0;
    flush_done_d = 1'b0;
    flush_entry  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d     = ST_FLUSH;
          flush_entry = 1'b1;
        end else if (enable) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        fifo_rd_en = !fifo_empty && (occ < 3'd2);
        if (flush) begin
          state_d     = ST_FLUSH;
          flush_entry = 1'b1;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_empty && !inflight_q) begin
          flush_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skid buffer: captures returning data, advances head on transfer; flush discards everything.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    cnt_d      = cnt_q;
    wc_d       = wc_q;
    inflight_d = fifo_rd_en && !fifo_empty;
    if (flush_entry) begin
      skid0_d = '0;
      skid1_d = '0;
      cnt_d   = 2'd0;
      wc_d    = '0;
    end else if (state_q != ST_FLUSH) begin
      if (transfer) wc_d = wc_q + CNT_WIDTH'(1);
      unique case ({inflight_q, transfer})
        2'b01: begin
          skid0_d = skid1_q;
          cnt_d   = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) skid0_d = fifo_data;
          else               skid1_d = fifo_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            skid0_d = fifo_data;
          end else begin
            skid0_d = skid1_q;
            skid1_d = fifo_data;
          end
        end
        default: ;
      endcase
    end
    valid_d = (cnt_d != 2'd0);
    busy_d  = (state_d != ST_IDLE) || (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      skid0_q      <= '0;
      skid1_q      <= '0;
      cnt_q        <= 2'd0;
      inflight_q   <= 1'b0;
      valid_q      <= 1'b0;
      wc_q         <= '0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      valid_q      <= valid_d;
      wc_q         <= wc_d;
      flush_done_q <= flush_done_d;
      busy_q       <= busy_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = skid0_q;
  assign flush_done = flush_done_q;
  assign busy       = busy_q;
  assign word_count = wc_q;

`ifdef FIFO_RD_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = ^skid0_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed bench for fifo_read_streamer with a behavioural FIFO model and transfer monitor.
// Build with FIFO_RD_PARITY_EN defined to also exercise out_parity.
module tb_fifo_read_streamer;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, enable, flush, fifo_empty, fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          out_valid, out_ready, flush_done, busy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] word_count;
`ifdef FIFO_RD_PARITY_EN
  logic          out_parity;
`endif

  fifo_read_streamer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush_done(flush_done), .busy(busy), .word_count(word_count)
`ifdef FIFO_RD_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: 1-cycle read latency.
  logic [DW-1:0] mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] recv [$];
  int            xfer_total = 0;
  int            rd_viol = 0;
  int            occ_viol = 0;
  logic          chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      recv.push_back(out_data);
      xfer_total <= xfer_total + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en && fifo_empty) rd_viol <= rd_viol + 1;
    if (chk_en && (rd_ptr - xfer_total > 2)) occ_viol <= occ_viol + 1;
  end

  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr % 256] = d;
    wr_ptr++;
  endtask

  task automatic wait_recv(input string tag, input int n);
    for (int i = 0; i < 300 && recv.size() < n; i++) step();
    chk(tag, 32'(recv.size()), 32'(n));
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic do_flush(input string tag);
    int pulses;
    pulses = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (flush_done) pulses++;
      step();
    end
    chk(tag, 32'(pulses), 32'd1);
  endtask

  int base;
  int r0;

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
`ifdef FIFO_RD_PARITY_EN
    chk("rst_parity", 32'(out_parity), 32'd0);
`endif
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Basic stream and 2-cycle pop-to-valid latency
    push(8'h11); push(8'h22); push(8'h33);
    out_ready = 1'b1;
    enable = 1'b1;
    step();
    chk("t2_first_rd_en", 32'(fifo_rd_en), 32'd1);
    step();
    chk("t2_valid_n1", 32'(out_valid), 32'd0);
    step();
    chk("t2_valid_n2", 32'(out_valid), 32'd1);
    chk("t2_data_n2", 32'(out_data), 32'h11);
    wait_recv("t2_count", 3);
    chk("t2_w0", 32'(recv[0]), 32'h11);
    chk("t2_w1", 32'(recv[1]), 32'h22);
    chk("t2_w2", 32'(recv[2]), 32'h33);
    chk("t2_wc", 32'(word_count), 32'd3);
    enable = 1'b0;
    repeat (3) step();
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // Backpressure: only two words may be popped
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    out_ready = 1'b0;
    base = rd_ptr;
    r0 = recv.size();
    enable = 1'b1;
    repeat (12) step();
    chk("t4_popped", 32'(rd_ptr - base), 32'd2);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_data", 32'(out_data), 32'h40);
    repeat (3) step();
    chk("t4_data_stable", 32'(out_data), 32'h40);
    out_ready = 1'b1;
    wait_recv("t4_count", r0 + 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t4_w%0d", i), 32'(recv[r0 + i]), 32'(8'h40 + i));

    // Toggling ready
    r0 = recv.size();
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    for (int i = 0; i < 200 && recv.size() < r0 + 16; i++) begin
      out_ready = ~out_ready;
      step();
    end
    chk("t3_count", 32'(recv.size()), 32'(r0 + 16));
    for (int i = 0; i < 16; i++) chk($sformatf("t3_w%0d", i), 32'(recv[r0 + i]), 32'(8'h80 + i));
    chk("t3_rd_viol", 32'(rd_viol), 32'd0);
    chk("t3_occ_viol", 32'(occ_viol), 32'd0);
    chk("t3_wc_wrapped", 32'(word_count), 32'd8);

    // 4-bit counter wrap after 17 transfers from zero
    out_ready = 1'b1;
    enable = 1'b0;
    step();
    do_flush("t6_flush_pulse");
    chk("t6_wc_cleared", 32'(word_count), 32'd0);
    r0 = recv.size();
    for (int i = 0; i < 17; i++) push(8'(8'hC0 + i));
    enable = 1'b1;
    wait_recv("t6_count", r0 + 17);
    step();
    chk("t6_wc", 32'(word_count), 32'd1);
    chk_en = 1'b0;

    // Flush with one buffered word and five in the FIFO
    out_ready = 1'b0;
    push(8'hA0);
    wait_valid("t5_valid_before");
    enable = 1'b0;
    step();
    for (int i = 0; i < 5; i++) push(8'(8'hA1 + i));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_valid_after", 32'(out_valid), 32'd0);
    chk("t5_wc", 32'(word_count), 32'd0);
    chk("t5_busy_flush", 32'(busy), 32'd1);
    base = 0;
    for (int i = 0; i < 40; i++) begin
      if (flush_done) base++;
      step();
    end
    chk("t5_done_pulses", 32'(base), 32'd1);
    chk("t5_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_valid_end", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream with two words buffered
    enable = 1'b1;
    out_ready = 1'b1;
    push(8'hD0);
    wait_recv("t1_prime", recv.size() + 1);
    out_ready = 1'b0;
    push(8'hD1); push(8'hD2); push(8'hD3);
    repeat (6) step();
    chk("t1_valid_pre", 32'(out_valid), 32'd1);
    chk("t1_wc_pre", 32'(word_count), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_data", 32'(out_data), 32'd0);
    chk("t1_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_wc", 32'(word_count), 32'd0);
    enable = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_flush("t1_drain_pulse");

    // Data (and parity when enabled) for 0x07 and 0x03
    push(8'h07); push(8'h03);
    enable = 1'b1;
    repeat (6) step();
    chk("p_data07", 32'(out_data), 32'h07);
`ifdef FIFO_RD_PARITY_EN
    chk("p_parity07", 32'(out_parity), 32'd1);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("p_data03", 32'(out_data), 32'h03);
`ifdef FIFO_RD_PARITY_EN
    chk("p_parity03", 32'(out_parity), 32'd0);
`endif
    chk("p_rd_viol", 32'(rd_viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
